argmax_classifier: RTL and testbench
====================================

Name: argmax_classifier

Overview:
- Final output stage of the inference pipeline.
- Sits directly downstream of the last layer's scaler and consumes its (index, value, enable) byte stream, one frame of CELL_AMOUNT beats per inference.
- Tracks the running maximum across each frame and emits the winning class index and its score.
- The result is held in a one-entry valid/ready output register for the host side.

Parameters:
- DATA_WIDTH, 8, width of input_index, input_value, output_class and output_score.
- CELL_AMOUNT, 4, beats per frame (number of classes); legal range 2..2^DATA_WIDTH.

Ports:
- clk  input  1  clock; all state updates on posedge.
- reset_n  input  1  asynchronous, active-low reset.
- input_index  input  DATA_WIDTH  class index of current beat (scaler output_index).
- input_value  input  DATA_WIDTH  unsigned scaled activation (scaler output_value).
- input_enable  input  1  beat valid (scaler output_enable); no back-pressure upstream.
- output_class  output  DATA_WIDTH  index of the maximum value in the last completed frame.
- output_score  output  DATA_WIDTH  maximum value of that frame.
- output_valid  output  1  result pending.
- output_ready  input  1  consumer accepts the result when output_valid && output_ready.
- output_overrun  output  1  sticky; a completed frame was dropped.
- output_seq_error  output  1  sticky; sequence violation (macro only, else tied 0).

Behaviour:
- Reset (async assert, sync-safe deassert): state IDLE, beat counter 0, running max/idx 0; all outputs 0.
- States: IDLE (waiting for first beat), ACCUM (mid-frame).
- IDLE + enable beat: captures value/index as running max, counter=1, goes to ACCUM.
- ACCUM + enable beat: replaces the running max only if value > max (strict). Ties therefore keep the lowest index. Counter increments.
- input_enable low: all state holds. Gaps within a frame are legal.
- Beat position comes from the internal counter. input_index is only captured as the class label; the counter is authoritative.
- Frame completion: the beat at position CELL_AMOUNT-1. The comparison includes that beat.
  - Result registered on the same edge; output_valid high the cycle after the last beat (latency 1).
  - Counter returns to 0 and state to IDLE. A beat in the very next cycle starts a new frame (back-to-back frames supported).
- Output register: output_class/output_score stable while output_valid=1. Cleared to invalid on handshake.
- Completion while output_valid=1 and output_ready=0: new result is dropped, the old one is kept, output_overrun set (sticky until reset).
- Completion in the same cycle as a handshake: new result loads, output_valid stays 1, no overrun.
- Arithmetic: unsigned DATA_WIDTH compare only; no widening.
- Reset mid-frame: the partial frame is discarded and the pending result is lost.

Optional Feature:
- Macro: ARGMAX_SEQ_CHECK_EN.
- When defined, every enabled beat's input_index is compared to the internal counter.
- On mismatch:
  - output_seq_error set (sticky).
  - Partial frame aborted, state returns to IDLE.
  - If the offending beat has input_index==0, it starts a new frame in the same cycle. Otherwise it is discarded.
- When undefined: input_index is never compared, output_seq_error is tied 0, and no checking logic is synthesised.

Decomposition:
- Shared package:
  - argmax state enum {IDLE, ACCUM}.
  - result struct {class, score}.
  - localparam for counter width, $clog2(CELL_AMOUNT+1).
- One natural sub-module: argmax_result_holder. It is the one-entry valid/ready register with overrun detection, reusable by other stream-to-host stages.

Test Plan:
- Frame 254,251,159,150 at indices 0..3 (scaler golden stream) -> output_valid one cycle after index 3 beat, class 0, score 254.
- Frame 10,200,200,5 -> class 1, score 200 (tie keeps lowest index).
- Two back-to-back frames {1,2,3,4} then {9,8,7,6}, output_ready held 0 -> first result kept (class 3, score 4), output_overrun=1. Then assert output_ready -> valid drops, overrun stays 1.
- Frame with enable low for 3 cycles between beats 1 and 2, values 5,6,7,8 -> class 3, score 8. Completing a second frame in the same cycle as the handshake -> valid stays high with new data, overrun 0.
- reset_n pulsed low after beat 2 -> all outputs 0 immediately. Next full frame 3,9,1,2 -> class 1, score 9.
- (ARGMAX_SEQ_CHECK_EN) indices 0,1,3 -> seq_error=1, no result. A following clean frame 0..3 with values 4,4,4,4 -> class 0, score 4.

Source files
------------

// File: rtl/argmax_classifier_pkg.sv
// Shared types and sizing helpers for the argmax classifier output stage.
package argmax_classifier_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      ACCUM = 1'b1
   } argmax_state_e;

   localparam int unsigned ARGMAX_DATA_WIDTH  = 8;
   localparam int unsigned ARGMAX_CELL_AMOUNT = 4;

   function automatic int unsigned argmax_cnt_width(input int unsigned cells);
      return $clog2(cells + 1);
   endfunction

   localparam int unsigned ARGMAX_CNT_WIDTH = argmax_cnt_width(ARGMAX_CELL_AMOUNT);

   typedef struct packed {
      logic [ARGMAX_DATA_WIDTH-1:0] cls;
      logic [ARGMAX_DATA_WIDTH-1:0] score;
   } argmax_result_t;

endpackage

// File: rtl/argmax_classifier_result_holder.sv
// One-entry valid/ready result register; a load that finds the slot occupied
// and not being drained is dropped and flagged in a sticky overrun bit.
module argmax_result_holder #(
   parameter type payload_t = logic [15:0]
) (
   input  logic     clk,
   input  logic     rst_n,
   input  logic     i_load,
   input  payload_t i_data,
   input  logic     i_ready,
   output payload_t o_data,
   output logic     o_valid,
   output logic     o_overrun
);

   payload_t r_data;
   logic     r_valid;
   logic     r_overrun;
   logic     w_free;

   // Slot is writable when empty or being handed off this very cycle.
   assign w_free = ~r_valid | i_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_data    <= '0;
         r_valid   <= 1'b0;
         r_overrun <= 1'b0;
      end else begin
         if (i_load && w_free) begin
            r_data  <= i_data;
            r_valid <= 1'b1;
         end else if (i_load) begin
            r_overrun <= 1'b1;
         end else if (r_valid && i_ready) begin
            r_valid <= 1'b0;
         end
      end
   end

   assign o_data    = r_data;
   assign o_valid   = r_valid;
   assign o_overrun = r_overrun;

endmodule

// File: rtl/argmax_classifier.sv
// Frame-wise argmax over the scaler byte stream, result held for the host.
// Optional index/sequence checking is built when ARGMAX_SEQ_CHECK_EN is defined.
module argmax_classifier
   import argmax_classifier_pkg::*;
#(
   parameter int unsigned DATA_WIDTH  = ARGMAX_DATA_WIDTH,
   parameter int unsigned CELL_AMOUNT = ARGMAX_CELL_AMOUNT
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic [DATA_WIDTH-1:0] input_index,
   input  logic [DATA_WIDTH-1:0] input_value,
   input  logic                  input_enable,
   output logic [DATA_WIDTH-1:0] output_class,
   output logic [DATA_WIDTH-1:0] output_score,
   output logic                  output_valid,
   input  logic                  output_ready,
   output logic                  output_overrun,
   output logic                  output_seq_error
);

   localparam int unsigned      CNT_W     = argmax_cnt_width(CELL_AMOUNT);
   localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(CELL_AMOUNT - 1);

   typedef struct packed {
      logic [DATA_WIDTH-1:0] cls;
      logic [DATA_WIDTH-1:0] score;
   } result_t;

   argmax_state_e         r_state;
   argmax_state_e         w_state_nxt;
   logic [CNT_W-1:0]      r_cnt;
   logic [CNT_W-1:0]      w_cnt_nxt;
   logic [DATA_WIDTH-1:0] r_max;
   logic [DATA_WIDTH-1:0] w_max_nxt;
   logic [DATA_WIDTH-1:0] r_idx;
   logic [DATA_WIDTH-1:0] w_idx_nxt;
   logic                  w_gt;
   logic                  w_start;
   logic                  w_done;
   logic                  w_seq_bad;
   result_t               w_result;
   result_t               w_held;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= IDLE;
         r_cnt   <= '0;
         r_max   <= '0;
         r_idx   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_max   <= w_max_nxt;
         r_idx   <= w_idx_nxt;
      end
   end

   always_comb begin
      w_state_nxt    = r_state;
      w_cnt_nxt      = r_cnt;
      w_max_nxt      = r_max;
      w_idx_nxt      = r_idx;
      w_start        = 1'b0;
      w_done         = 1'b0;
      // Strict compare: an equal later value never displaces the earlier index.
      w_gt           = input_value > r_max;
      w_result.cls   = w_gt ? input_index : r_idx;
      w_result.score = w_gt ? input_value : r_max;

      if (input_enable) begin
         if (w_seq_bad) begin
            w_state_nxt = IDLE;
            w_cnt_nxt   = '0;
            w_start     = (input_index == '0);
         end else if (r_state == IDLE) begin
            w_start = 1'b1;
         end else if (r_cnt == LAST_BEAT) begin
            w_done      = 1'b1;
            w_state_nxt = IDLE;
            w_cnt_nxt   = '0;
         end else begin
            w_cnt_nxt = r_cnt + 1'b1;
            w_max_nxt = w_result.score;
            w_idx_nxt = w_result.cls;
         end
      end

      if (w_start) begin
         w_state_nxt = ACCUM;
         w_cnt_nxt   = CNT_W'(1);
         w_max_nxt   = input_value;
         w_idx_nxt   = input_index;
      end
   end

`ifdef ARGMAX_SEQ_CHECK_EN
   logic r_seq_err;

   // The counter is authoritative; any label disagreeing with it aborts the frame.
   assign w_seq_bad = (32'(input_index) != 32'(r_cnt));

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_seq_err <= 1'b0;
      end else if (input_enable && w_seq_bad) begin
         r_seq_err <= 1'b1;
      end
   end

   assign output_seq_error = r_seq_err;
`else
   assign w_seq_bad        = 1'b0;
   assign output_seq_error = 1'b0;
`endif

   argmax_result_holder #(
      .payload_t (result_t)
   ) u_holder (
      .clk       (clk),
      .rst_n     (reset_n),
      .i_load    (w_done),
      .i_data    (w_result),
      .i_ready   (output_ready),
      .o_data    (w_held),
      .o_valid   (output_valid),
      .o_overrun (output_overrun)
   );

   assign output_class = w_held.cls;
   assign output_score = w_held.score;

endmodule

// File: tb/tb_argmax_classifier.sv
// Directed self-checking bench for argmax_classifier with a frame-level reference model.
module tb_argmax_classifier;
   import argmax_classifier_pkg::*;

   localparam int unsigned DW    = 8;
   localparam int unsigned CELLS = 4;

   logic          clk          = 1'b0;
   logic          reset_n      = 1'b0;
   logic          input_enable = 1'b0;
   logic          output_ready = 1'b0;
   logic [DW-1:0] input_index  = '0;
   logic [DW-1:0] input_value  = '0;
   logic [DW-1:0] output_class;
   logic [DW-1:0] output_score;
   logic          output_valid;
   logic          output_overrun;
   logic          output_seq_error;

   int checks = 0;
   int errors = 0;

   argmax_classifier #(
      .DATA_WIDTH  (DW),
      .CELL_AMOUNT (CELLS)
   ) dut (
      .clk              (clk),
      .reset_n          (reset_n),
      .input_index      (input_index),
      .input_value      (input_value),
      .input_enable     (input_enable),
      .output_class     (output_class),
      .output_score     (output_score),
      .output_valid     (output_valid),
      .output_ready     (output_ready),
      .output_overrun   (output_overrun),
      .output_seq_error (output_seq_error)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference model: collect a frame's beats, pick the first maximum once full.
   int unsigned    m_vals[$];
   int unsigned    m_idxs[$];
   bit             m_valid   = 1'b0;
   bit             m_overrun = 1'b0;
   bit             m_seq     = 1'b0;
   argmax_result_t m_res     = '0;

   always @(posedge clk or negedge reset_n) begin : model
      bit             finished;
      bit             handoff;
      int unsigned    best;
      argmax_result_t fr;
      if (!reset_n) begin
         m_vals.delete();
         m_idxs.delete();
         m_valid   = 1'b0;
         m_overrun = 1'b0;
         m_seq     = 1'b0;
         m_res     = '0;
      end else begin
         finished = 1'b0;
         fr       = '0;
         handoff  = m_valid && output_ready;
         if (input_enable) begin
`ifdef ARGMAX_SEQ_CHECK_EN
            if (int'(input_index) != m_vals.size()) begin
               m_seq = 1'b1;
               m_vals.delete();
               m_idxs.delete();
            end
            if (int'(input_index) == m_vals.size()) begin
               m_vals.push_back(int'(input_value));
               m_idxs.push_back(int'(input_index));
            end
`else
            m_vals.push_back(int'(input_value));
            m_idxs.push_back(int'(input_index));
`endif
            if (m_vals.size() == CELLS) begin
               best = 0;
               for (int i = 1; i < int'(CELLS); i++)
                  if (m_vals[i] > m_vals[best]) best = i;
               fr.cls   = DW'(m_idxs[best]);
               fr.score = DW'(m_vals[best]);
               finished = 1'b1;
               m_vals.delete();
               m_idxs.delete();
            end
         end
         if (finished) begin
            if (!m_valid || handoff) begin
               m_res   = fr;
               m_valid = 1'b1;
            end else begin
               m_overrun = 1'b1;
            end
         end else if (handoff) begin
            m_valid = 1'b0;
         end
      end
   end

   always @(negedge clk) begin
      chk("valid", 32'(output_valid), 32'(m_valid));
      chk("overrun", 32'(output_overrun), 32'(m_overrun));
      chk("seq_error", 32'(output_seq_error), 32'(m_seq));
      if (m_valid) begin
         chk("class", 32'(output_class), 32'(m_res.cls));
         chk("score", 32'(output_score), 32'(m_res.score));
      end
   end

   task automatic cyc(input logic en, input int unsigned idx, input int unsigned val);
      input_enable = en;
      input_index  = DW'(idx);
      input_value  = DW'(val);
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int unsigned n);
      for (int unsigned i = 0; i < n; i++) cyc(1'b0, 0, 0);
   endtask

   task automatic frame4(input int unsigned v0, input int unsigned v1,
                         input int unsigned v2, input int unsigned v3);
      cyc(1'b1, 0, v0);
      cyc(1'b1, 1, v1);
      cyc(1'b1, 2, v2);
      cyc(1'b1, 3, v3);
   endtask

   task automatic expect_out(input string nm, input logic vld, input int unsigned cls,
                             input int unsigned score, input logic ovr);
      chk({nm, "_valid"}, 32'(output_valid), 32'(vld));
      chk({nm, "_class"}, 32'(output_class), cls);
      chk({nm, "_score"}, 32'(output_score), score);
      chk({nm, "_overrun"}, 32'(output_overrun), 32'(ovr));
   endtask

   task automatic drain(input string nm);
      output_ready = 1'b1;
      idle(1);
      output_ready = 1'b0;
      chk({nm, "_drained"}, 32'(output_valid), 32'd0);
   endtask

   initial begin
      idle(2);
      expect_out("reset", 1'b0, 0, 0, 1'b0);
      chk("reset_seq_error", 32'(output_seq_error), 32'd0);
      reset_n = 1'b1;
      idle(1);

      // Golden scaler stream; result appears one cycle after the last beat.
      cyc(1'b1, 0, 254);
      cyc(1'b1, 1, 251);
      cyc(1'b1, 2, 159);
      chk("golden_latency", 32'(output_valid), 32'd0);
      cyc(1'b1, 3, 150);
      expect_out("golden", 1'b1, 0, 254, 1'b0);
      drain("golden");

      frame4(10, 200, 200, 5);
      expect_out("tie", 1'b1, 1, 200, 1'b0);
      drain("tie");

      frame4(0, 0, 0, 0);
      expect_out("zeros", 1'b1, 0, 0, 1'b0);
      drain("zeros");

      frame4(7, 3, 255, 255);
      expect_out("maxval", 1'b1, 2, 255, 1'b0);
      drain("maxval");

      // Gapped frame, then a completion coinciding with the handshake.
      cyc(1'b1, 0, 5);
      cyc(1'b1, 1, 6);
      idle(3);
      cyc(1'b1, 2, 7);
      cyc(1'b1, 3, 8);
      expect_out("gap", 1'b1, 3, 8, 1'b0);
      cyc(1'b1, 0, 1);
      cyc(1'b1, 1, 50);
      cyc(1'b1, 2, 2);
      output_ready = 1'b1;
      cyc(1'b1, 3, 3);
      output_ready = 1'b0;
      expect_out("handoff", 1'b1, 1, 50, 1'b0);
      drain("handoff");

      // Back-to-back frames with no consumer: second result dropped.
      frame4(1, 2, 3, 4);
      expect_out("b2b_first", 1'b1, 3, 4, 1'b0);
      frame4(9, 8, 7, 6);
      expect_out("b2b_overrun", 1'b1, 3, 4, 1'b1);
      drain("b2b");
      chk("overrun_sticky", 32'(output_overrun), 32'd1);

      // Reset mid-frame with a result pending.
      frame4(20, 30, 40, 10);
      cyc(1'b1, 0, 100);
      cyc(1'b1, 1, 200);
      reset_n = 1'b0;
      #1;
      expect_out("async_reset", 1'b0, 0, 0, 1'b0);
      idle(2);
      reset_n = 1'b1;
      idle(1);
      frame4(3, 9, 1, 2);
      expect_out("post_reset", 1'b1, 1, 9, 1'b0);
      drain("post_reset");

`ifdef ARGMAX_SEQ_CHECK_EN
      cyc(1'b1, 0, 50);
      cyc(1'b1, 1, 60);
      cyc(1'b1, 3, 70);
      chk("seq_flag", 32'(output_seq_error), 32'd1);
      idle(1);
      chk("seq_no_result", 32'(output_valid), 32'd0);
      frame4(4, 4, 4, 4);
      expect_out("seq_recover", 1'b1, 0, 4, 1'b0);
      drain("seq_recover");
`else
      chk("seq_error_tied", 32'(output_seq_error), 32'd0);
`endif

      idle(3);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
